// File: rtl/drop_scheduler.sv
// drop_scheduler: owns the falling-drop slots, steps them on a level-scaled
// timer, retires floor hits and shares one random-X generator round-robin.
module drop_scheduler #(
  parameter int NUM_DROPS        = 4,
  parameter int SCREEN_H         = 480,
  parameter int DROP_H           = 32,
  parameter int X_MAX            = 568,
  parameter int OFFSCREEN_Y      = 500,
  parameter int TICK_INIT        = 500000,
  parameter int TICK_MIN         = 100000,
  parameter int TICK_STEP        = 25000,
  parameter int DODGES_PER_LEVEL = 8,
  parameter int SPAWN_GAP        = 120
) (
  input  logic                      clk_25MHz,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      freeze,
  output logic                      rng_req,
  input  logic                      rng_ack,
  input  logic [9:0]                rng_x,
  output logic [10*NUM_DROPS-1:0]   drop_x,
  output logic [10*NUM_DROPS-1:0]   drop_y,
  output logic [NUM_DROPS-1:0]      drop_active,
  output logic [3:0]                level,
  output logic [15:0]               dodge_count
);

  localparam int FLOOR = SCREEN_H - DROP_H;
  localparam int IW    = $clog2(NUM_DROPS);
  localparam int PW    = $clog2(TICK_INIT + 1);
  localparam int GW    = $clog2(SPAWN_GAP + 1);
  localparam int LW    = $clog2(DODGES_PER_LEVEL + 9);
  localparam int XW    = 10 * NUM_DROPS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FROZEN
  } state_t;

  state_t state_q, state_n;

  logic [XW-1:0]        x_q, x_n;
  logic [XW-1:0]        y_q, y_n;
  logic [NUM_DROPS-1:0] act_q, act_n;
  logic [NUM_DROPS-1:0] pend_q, pend_n;
  logic                 req_q, req_n;
  logic [IW-1:0]        gnt_q, gnt_n;
  logic [IW-1:0]        rr_q, rr_n;
  logic [3:0]           lvl_q, lvl_n;
  logic [15:0]          dodge_q, dodge_n;
  logic [PW-1:0]        period_q, period_n;
  logic [PW-1:0]        cnt_q, cnt_n;
  logic [GW-1:0]        gap_q, gap_n;
  logic [LW-1:0]        lvc_q, lvc_n;

  logic                 step;
  logic                 allow;
  logic                 found;
  logic [IW-1:0]        pick;
  logic [IW:0]          idx;
  logic [3:0]           nret;
  logic [LW-1:0]        sum;
  logic [9:0]           ynew;

  assign step = (state_q == RUN) &&
                (cnt_q == period_q - PW'(1));

  always_comb begin
    state_n  = state_q;
    x_n      = x_q;
    y_n      = y_q;
    act_n    = act_q;
    pend_n   = pend_q;
    req_n    = req_q;
    gnt_n    = gnt_q;
    rr_n     = rr_q;
    lvl_n    = lvl_q;
    dodge_n  = dodge_q;
    period_n = period_q;
    cnt_n    = cnt_q;
    gap_n    = gap_q;
    lvc_n    = lvc_q;
    nret     = '0;
    sum      = '0;
    ynew     = '0;
    found    = 1'b0;
    pick     = '0;
    idx      = '0;
    allow    = 1'b0;

    unique case (state_q)
      IDLE:    if (run) state_n = RUN;
      RUN:     if (!run) state_n = IDLE;
               else if (freeze) state_n = FROZEN;
      FROZEN:  if (!run) state_n = IDLE;
               else if (!freeze) state_n = RUN;
      default: state_n = IDLE;
    endcase

    if (state_q == RUN)
      cnt_n = step ? '0 : cnt_q + PW'(1);

    if (step) begin
      for (int i = 0; i < NUM_DROPS; i++) begin
        if (act_q[i]) begin
          ynew = y_q[i*10 +: 10] + 10'd1;
          y_n[i*10 +: 10] = ynew;
          if (ynew == 10'(FLOOR)) begin
            act_n[i]  = 1'b0;
            pend_n[i] = 1'b1;
            nret      = nret + 4'd1;
          end
        end
      end
      if (gap_q != GW'(SPAWN_GAP))
        gap_n = gap_q + GW'(1);
      dodge_n = dodge_q + 16'(nret);
      // lvc tracks progress toward the next multiple of the level size
      sum   = lvc_q + LW'(nret);
      lvc_n = sum % LW'(DODGES_PER_LEVEL);
      if (sum >= LW'(DODGES_PER_LEVEL)) begin
        if (lvl_q != 4'd15)
          lvl_n = lvl_q + 4'd1;
        if (int'(period_q) >= TICK_MIN + TICK_STEP)
          period_n = period_q - PW'(TICK_STEP);
        else
          period_n = PW'(TICK_MIN);
      end
    end

    for (int k = 0; k < NUM_DROPS; k++) begin
      idx = {1'b0, rr_q} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_DROPS))
        idx = idx - (IW+1)'(NUM_DROPS);
      if (!found && pend_q[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end

    allow = (state_q == RUN) && !req_q && found &&
            ((gap_q == GW'(SPAWN_GAP)) || !(|act_q));
    if (allow) begin
      req_n = 1'b1;
      gnt_n = pick;
    end

    // granted slot is pending, so the step above never touched it
    if (req_q && rng_ack) begin
      for (int i = 0; i < NUM_DROPS; i++) begin
        if (gnt_q == IW'(i)) begin
          x_n[i*10 +: 10] = (rng_x > 10'(X_MAX)) ?
                            10'(X_MAX) : rng_x;
          y_n[i*10 +: 10] = '0;
          act_n[i]        = 1'b1;
          pend_n[i]       = 1'b0;
        end
      end
      gap_n = '0;
      rr_n  = (gnt_q == IW'(NUM_DROPS - 1)) ?
              '0 : gnt_q + IW'(1);
      req_n = 1'b0;
    end

    if (state_q == IDLE && run) begin
      pend_n   = '1;
      act_n    = '0;
      lvl_n    = '0;
      dodge_n  = '0;
      gap_n    = '0;
      lvc_n    = '0;
      cnt_n    = '0;
      period_n = PW'(TICK_INIT);
      req_n    = 1'b0;
    end

    if (!run) begin
      act_n  = '0;
      pend_n = '0;
      req_n  = 1'b0;
    end

    for (int i = 0; i < NUM_DROPS; i++)
      if (!act_n[i])
        y_n[i*10 +: 10] = 10'(OFFSCREEN_Y);
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= {NUM_DROPS{10'(OFFSCREEN_Y)}};
      act_q    <= '0;
      pend_q   <= '0;
      req_q    <= 1'b0;
      gnt_q    <= '0;
      rr_q     <= '0;
      lvl_q    <= '0;
      dodge_q  <= '0;
      period_q <= PW'(TICK_INIT);
      cnt_q    <= '0;
      gap_q    <= '0;
      lvc_q    <= '0;
    end else begin
      state_q  <= state_n;
      x_q      <= x_n;
      y_q      <= y_n;
      act_q    <= act_n;
      pend_q   <= pend_n;
      req_q    <= req_n;
      gnt_q    <= gnt_n;
      rr_q     <= rr_n;
      lvl_q    <= lvl_n;
      dodge_q  <= dodge_n;
      period_q <= period_n;
      cnt_q    <= cnt_n;
      gap_q    <= gap_n;
      lvc_q    <= lvc_n;
    end
  end

  assign rng_req     = req_q;
  assign drop_x      = x_q;
  assign drop_y      = y_q;
  assign drop_active = act_q;
  assign level       = lvl_q;
  assign dodge_count = dodge_q;

endmodule

// File: tb/tb_drop_scheduler.sv
// tb_drop_scheduler: directed cycle-exact walk through spawn, clamp, step,
// retire, level-up, freeze, run drop and async reset.
module tb_drop_scheduler;

  localparam int N = 2;

  logic            clk_25MHz = 1'b0;
  logic            reset;
  logic            run;
  logic            freeze;
  logic            rng_req;
  logic            rng_ack;
  logic [9:0]      rng_x;
  logic [10*N-1:0] drop_x;
  logic [10*N-1:0] drop_y;
  logic [N-1:0]    drop_active;
  logic [3:0]      level;
  logic [15:0]     dodge_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  drop_scheduler #(
    .NUM_DROPS        (N),
    .SCREEN_H         (40),
    .DROP_H           (32),
    .X_MAX            (568),
    .OFFSCREEN_Y      (500),
    .TICK_INIT        (10),
    .TICK_MIN         (4),
    .TICK_STEP        (2),
    .DODGES_PER_LEVEL (2),
    .SPAWN_GAP        (3)
  ) dut (
    .clk_25MHz   (clk_25MHz),
    .reset       (reset),
    .run         (run),
    .freeze      (freeze),
    .rng_req     (rng_req),
    .rng_ack     (rng_ack),
    .rng_x       (rng_x),
    .drop_x      (drop_x),
    .drop_y      (drop_y),
    .drop_active (drop_active),
    .level       (level),
    .dodge_count (dodge_count)
  );

  always #5 clk_25MHz = ~clk_25MHz;

  function automatic logic [31:0] pk(input int s1, input int s0);
    return 32'({10'(s1), 10'(s0)});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25MHz);
    #1;
    cyc++;
  endtask

  task automatic go(input int n);
    while (cyc < n) tick();
  endtask

  task automatic ack(input int x);
    rng_ack = 1'b1;
    rng_x   = 10'(x);
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, "_x"}, 32'(drop_x), 32'd0);
    chk({tag, "_y"}, 32'(drop_y), pk(500, 500));
    chk({tag, "_act"}, 32'(drop_active), 32'd0);
    chk({tag, "_req"}, 32'(rng_req), 32'd0);
    chk({tag, "_lvl"}, 32'(level), 32'd0);
    chk({tag, "_dodge"}, 32'(dodge_count), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    run     = 1'b0;
    freeze  = 1'b0;
    rng_ack = 1'b0;
    rng_x   = '0;
    #12;
    chk_idle_out("rst");
    @(posedge clk_25MHz);
    #1;
    reset = 1'b0;
    tick();
    tick();
    run = 1'b1;
    cyc = -1;

    go(1);   chk("req_first", 32'(rng_req), 32'd1);
    go(2);   ack(100);
    go(3);   rng_ack = 1'b0;
    chk("spawn0_x", 32'(drop_x), pk(0, 100));
    chk("spawn0_y", 32'(drop_y), pk(500, 0));
    chk("spawn0_act", 32'(drop_active), 32'd1);
    chk("spawn0_req", 32'(rng_req), 32'd0);
    go(9);   chk("pre_step", 32'(drop_y), pk(500, 0));
    go(10);  chk("step1", 32'(drop_y), pk(500, 1));
    go(30);  chk("gap_hold", 32'(rng_req), 32'd0);
    chk("y_e30", 32'(drop_y), pk(500, 3));
    go(31);  chk("gap_req", 32'(rng_req), 32'd1);
    go(32);  ack(900);
    go(33);  rng_ack = 1'b0;
    chk("clamp900", 32'(drop_x), pk(568, 100));
    chk("spawn1_y", 32'(drop_y), pk(0, 3));
    chk("spawn1_act", 32'(drop_active), 32'd3);
    go(79);  chk("y_e79", 32'(drop_y), pk(4, 7));
    go(80);  chk("retire_y", 32'(drop_y), pk(5, 500));
    chk("retire_act", 32'(drop_active), 32'd2);
    chk("dodge1", 32'(dodge_count), 32'd1);
    chk("lvl0", 32'(level), 32'd0);
    go(81);  chk("rr_req", 32'(rng_req), 32'd1);
    freeze = 1'b1;

    go(90);  chk("frz_req", 32'(rng_req), 32'd1);
    chk("frz_y", 32'(drop_y), pk(5, 500));
    go(100); ack(50);
    go(101); rng_ack = 1'b0;
    chk("frz_ack_x", 32'(drop_x), pk(568, 50));
    chk("frz_ack_y", 32'(drop_y), pk(5, 0));
    chk("frz_ack_act", 32'(drop_active), 32'd3);
    chk("frz_ack_req", 32'(rng_req), 32'd0);
    go(131); chk("frz_end_y", 32'(drop_y), pk(5, 0));
    freeze = 1'b0;
    go(139); chk("thaw_hold", 32'(drop_y), pk(5, 0));
    go(140); chk("thaw_step", 32'(drop_y), pk(6, 1));

    go(160); chk("lvlup_y", 32'(drop_y), pk(500, 3));
    chk("lvlup_act", 32'(drop_active), 32'd1);
    chk("dodge2", 32'(dodge_count), 32'd2);
    chk("lvl1", 32'(level), 32'd1);
    go(161); chk("req_s1", 32'(rng_req), 32'd1);
    go(162); ack(300);
    go(163); rng_ack = 1'b0;
    chk("x300", 32'(drop_x), pk(300, 50));
    chk("y_e163", 32'(drop_y), pk(0, 3));
    go(167); chk("p8_hold", 32'(drop_y), pk(0, 3));
    go(168); chk("p8_step", 32'(drop_y), pk(1, 4));

    go(191); chk("y_e191", 32'(drop_y), pk(3, 6));
    force dut.y_q = {10'd7, 10'd7};
    go(192);
    chk("dbl_act", 32'(drop_active), 32'd0);
    chk("dbl_dodge", 32'(dodge_count), 32'd4);
    chk("lvl2", 32'(level), 32'd2);
    release dut.y_q;
    go(193); chk("dbl_y", 32'(drop_y), pk(500, 500));
    chk("dbl_req", 32'(rng_req), 32'd1);
    go(194); ack(568);
    go(195); rng_ack = 1'b0;
    chk("x568", 32'(drop_x), pk(300, 568));
    chk("y_e195", 32'(drop_y), pk(500, 0));
    go(210); chk("p6_y", 32'(drop_y), pk(500, 3));
    go(211); chk("p6_req", 32'(rng_req), 32'd1);
    go(212); ack(569);
    go(213); rng_ack = 1'b0;
    chk("clamp569", 32'(drop_x), pk(568, 568));
    go(233); chk("y_e233", 32'(drop_y), pk(3, 6));
    force dut.y_q = {10'd7, 10'd7};
    go(234);
    chk("dbl2_dodge", 32'(dodge_count), 32'd6);
    chk("lvl3", 32'(level), 32'd3);
    release dut.y_q;
    go(235); chk("dbl2_y", 32'(drop_y), pk(500, 500));
    go(236); ack(1);
    go(237); rng_ack = 1'b0;
    chk("x1", 32'(drop_x), pk(568, 1));
    go(241); chk("p4_hold", 32'(drop_y), pk(500, 1));
    go(242); chk("p4_step", 32'(drop_y), pk(500, 2));
    go(247); chk("p4_req", 32'(rng_req), 32'd1);
    go(248); ack(2);
    go(249); rng_ack = 1'b0;
    chk("x2", 32'(drop_x), pk(2, 1));
    chk("y_e249", 32'(drop_y), pk(0, 3));
    force dut.y_q = {10'd7, 10'd7};
    go(250);
    chk("dbl3_dodge", 32'(dodge_count), 32'd8);
    chk("lvl4", 32'(level), 32'd4);
    release dut.y_q;
    go(251); chk("dbl3_req", 32'(rng_req), 32'd1);
    go(252); ack(3);
    go(253); rng_ack = 1'b0;
    go(257); chk("floor_hold", 32'(drop_y), pk(500, 1));
    go(258); chk("floor_step", 32'(drop_y), pk(500, 2));
    go(263); chk("late_req", 32'(rng_req), 32'd1);
    run = 1'b0;

    go(264); chk("stop_req", 32'(rng_req), 32'd0);
    chk("stop_y", 32'(drop_y), pk(500, 500));
    chk("stop_act", 32'(drop_active), 32'd0);
    chk("stop_lvl", 32'(level), 32'd4);
    chk("stop_dodge", 32'(dodge_count), 32'd8);
    ack(5);
    go(265); rng_ack = 1'b0;
    chk("ign_x", 32'(drop_x), pk(2, 3));
    chk("ign_act", 32'(drop_active), 32'd0);
    chk("ign_req", 32'(rng_req), 32'd0);
    run = 1'b1;
    go(266); chk("rerun_lvl", 32'(level), 32'd0);
    chk("rerun_dodge", 32'(dodge_count), 32'd0);
    go(267); chk("rerun_req", 32'(rng_req), 32'd1);
    go(268); ack(77);
    go(269); rng_ack = 1'b0;
    chk("rerun_x", 32'(drop_x), pk(77, 3));
    chk("rerun_act", 32'(drop_active), 32'd2);
    go(272);
    #2;
    reset = 1'b1;
    #1;
    chk_idle_out("arst");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
